// File: rtl/dcache_flush_arbiter.sv
// rtl/dcache_flush_arbiter.sv - shares the DCache flush port between requesters, coalescing pending requests
module dcache_flush_arbiter #(
    parameter int NrReq         = 4,
    parameter int TimeoutCycles = 1024
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [NrReq-1:0] req_i,
    output logic [NrReq-1:0] ack_o,
    output logic             err_o,
    output logic             flush_dcache_o,
    input  logic             flush_dcache_ack_i,
    input  logic             cache_busy_i,
    output logic             busy_o,
    output logic [NrReq-1:0] served_o,
    output logic             timeout_o
);

    localparam int CntWidth = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FLUSH = 2'd1,
        DONE  = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [NrReq-1:0]     mask_q, mask_d;
    logic [NrReq-1:0]     ack_q;
    logic [NrReq-1:0]     eff_req;
    logic [CntWidth-1:0]  cnt_q, cnt_d;
    logic                 err_q, err_d;
    logic                 timeout_q, timeout_d;
    logic                 wd_expire;

    generate
        if (TimeoutCycles == 0) begin : g_no_wd
            assign wd_expire = 1'b0;
        end else begin : g_wd
            localparam logic [CntWidth-1:0] CntLast = CntWidth'(TimeoutCycles - 1);
            assign wd_expire = (cnt_q == CntLast);
        end
    endgenerate

    // Masking with last cycle's ack keeps a requester from being re-served
    // while it is still lowering req the cycle after its completion pulse.
    assign eff_req   = req_i & ~ack_q;
    assign busy_o    = (state_q != IDLE) | (|eff_req);
    assign served_o  = (state_q != IDLE) ? mask_q : '0;
    assign timeout_o = timeout_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            mask_q    <= '0;
            ack_q     <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            mask_q    <= mask_d;
            ack_q     <= ack_o;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        mask_d         = mask_q;
        cnt_d          = cnt_q;
        err_d          = err_q;
        timeout_d      = timeout_q;
        flush_dcache_o = 1'b0;
        ack_o          = '0;
        err_o          = 1'b0;
        case (state_q)
            IDLE: begin
                if ((|eff_req) && !cache_busy_i) begin
                    mask_d  = eff_req;
                    cnt_d   = '0;
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                flush_dcache_o = 1'b1;
                cnt_d          = cnt_q + CntWidth'(1);
                // A cache ack in the final watchdog cycle still counts as success.
                if (flush_dcache_ack_i) begin
                    err_d   = 1'b0;
                    state_d = DONE;
                end else if (wd_expire) begin
                    err_d     = 1'b1;
                    timeout_d = 1'b1;
                    state_d   = DONE;
                end
            end
            DONE: begin
                ack_o   = mask_q & req_i;
                err_o   = err_q;
                cnt_d   = '0;
                mask_d  = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    a_ack_only_in_done: assert property (@(posedge clk_i) disable iff (rst_i)
        (state_q != DONE) |-> (ack_o == '0));
    a_no_flush_in_idle: assert property (@(posedge clk_i) disable iff (rst_i)
        (state_q == IDLE) |-> !flush_dcache_o);
    a_ack_in_mask: assert property (@(posedge clk_i) disable iff (rst_i)
        ((ack_o & ~mask_q) == '0));

endmodule
